// File: rtl/daq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | daq_pkg: shared types and helpers for the DAQ frame packer.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package daq_pkg;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_SEQ  = 3'd2,
    ST_HDR  = 3'd3,
    ST_DATA = 3'd4,
    ST_CSUM = 3'd5
  } state_e;

  function automatic int calc_nb(input int sample_w);
    return (sample_w + 7) / 8;
  endfunction

  function automatic logic [7:0] pack_header(input logic [3:0] nb, input logic [3:0] ch);
    return {nb, ch};
  endfunction

endpackage
`default_nettype wire

// File: rtl/daq_frame_packer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | daq_frame_packer_if: sample input, byte stream and status bundle.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface daq_frame_packer_if #(
  parameter int NUM_CH     = 4,
  parameter int SAMPLE_W   = 12,
  parameter int FIFO_DEPTH = 16
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic                smp_valid;
  logic [CH_W-1:0]     smp_ch;
  logic [SAMPLE_W-1:0] smp_data;
  logic                byte_valid;
  logic                byte_ready;
  logic [7:0]          byte_data;
  logic                ovf_clr;
  logic                overflow;
  logic [7:0]          drop_cnt;
  logic [15:0]         frame_cnt;
  logic [LVL_W-1:0]    fifo_level;

  modport slave (
    input  smp_valid, smp_ch, smp_data, byte_ready, ovf_clr,
    output byte_valid, byte_data, overflow, drop_cnt, frame_cnt, fifo_level
  );

  modport master (
    output smp_valid, smp_ch, smp_data, byte_ready, ovf_clr,
    input  byte_valid, byte_data, overflow, drop_cnt, frame_cnt, fifo_level
  );
endinterface
`default_nettype wire

// File: rtl/daq_sample_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | daq_sample_fifo: synchronous first-word-fall-through FIFO.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module daq_sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  // A pop frees a slot in the same cycle, so a full FIFO can still take a push.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q];
  assign level   = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    level_d  = level_q + LW'(do_push) - LW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end
endmodule
`default_nettype wire

// File: rtl/daq_frame_packer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | daq_frame_packer: buffers tagged ADC samples and emits framed bytes. |
// | DAQ_SEQ_BYTE_EN inserts a sequence byte after SYNC.  Revision: 1.0   |
// +----------------------------------------------------------------------+
module daq_frame_packer
  import daq_pkg::*;
#(
  parameter int         NUM_CH     = 4,
  parameter int         SAMPLE_W   = 12,
  parameter int         FIFO_DEPTH = 16,
  parameter logic [7:0] SYNC_BYTE  = DEFAULT_SYNC_BYTE
) (
  input  logic                clk,
  input  logic                rst,
  daq_frame_packer_if.slave   bus
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int NB    = calc_nb(SAMPLE_W);
  localparam int DW    = NB * 8;
  localparam int FW    = CH_W + SAMPLE_W;
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic                fifo_pop, fifo_full, fifo_empty;
  logic [FW-1:0]       fifo_head;
  logic [LVL_W-1:0]    fifo_level;
  logic [CH_W-1:0]     head_ch;
  logic [SAMPLE_W-1:0] head_data;
  logic                drop;

  state_e           state_q, state_d;
  logic [7:0]       hdr_q, hdr_d;
  logic [DW-1:0]    data_q, data_d;
  logic [1:0]       idx_q, idx_d;
  logic [7:0]       csum_q, csum_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;
  logic             byte_valid;
  logic [7:0]       byte_data;
`ifdef DAQ_SEQ_BYTE_EN
  logic [7:0]       seq_q, seq_d;
`endif

  daq_sample_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.smp_valid),
    .wdata ({bus.smp_ch, bus.smp_data}),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_ch   = fifo_head[FW-1 -: CH_W];
  assign head_data = fifo_head[SAMPLE_W-1:0];
  assign drop      = bus.smp_valid && fifo_full && !fifo_pop;

  // A clear arriving with a drop wins for the flag but still counts that drop.
  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (bus.ovf_clr) begin
      overflow_d = 1'b0;
      drop_cnt_d = drop ? 8'd1 : 8'd0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    data_d      = data_q;
    idx_d       = idx_q;
    csum_d      = csum_q;
    frame_cnt_d = frame_cnt_q;
    fifo_pop    = 1'b0;
    byte_valid  = 1'b0;
    byte_data   = 8'h00;
`ifdef DAQ_SEQ_BYTE_EN
    seq_d       = seq_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          hdr_d    = pack_header(4'(NB), 4'(head_ch));
          data_d   = DW'(head_data);
          idx_d    = 2'd0;
          csum_d   = 8'h00;
`ifdef DAQ_SEQ_BYTE_EN
          seq_d    = frame_cnt_q[7:0];
`endif
          state_d  = ST_SYNC;
        end
      end
      ST_SYNC: begin
        byte_valid = 1'b1;
        byte_data  = SYNC_BYTE;
        if (bus.byte_ready) begin
`ifdef DAQ_SEQ_BYTE_EN
          state_d = ST_SEQ;
`else
          state_d = ST_HDR;
`endif
        end
      end
`ifdef DAQ_SEQ_BYTE_EN
      ST_SEQ: begin
        byte_valid = 1'b1;
        byte_data  = seq_q;
        if (bus.byte_ready) begin
          csum_d  = csum_q ^ seq_q;
          state_d = ST_HDR;
        end
      end
`endif
      ST_HDR: begin
        byte_valid = 1'b1;
        byte_data  = hdr_q;
        if (bus.byte_ready) begin
          csum_d  = csum_q ^ hdr_q;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        // The frame register shifts left so the current byte is always on top.
        byte_valid = 1'b1;
        byte_data  = data_q[DW-1 -: 8];
        if (bus.byte_ready) begin
          csum_d = csum_q ^ data_q[DW-1 -: 8];
          data_d = data_q << 8;
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'(NB - 1)) state_d = ST_CSUM;
        end
      end
      ST_CSUM: begin
        byte_valid = 1'b1;
        byte_data  = csum_q;
        if (bus.byte_ready) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hdr_q       <= '0;
      data_q      <= '0;
      idx_q       <= '0;
      csum_q      <= '0;
      frame_cnt_q <= '0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
`ifdef DAQ_SEQ_BYTE_EN
      seq_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      data_q      <= data_d;
      idx_q       <= idx_d;
      csum_q      <= csum_d;
      frame_cnt_q <= frame_cnt_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
`ifdef DAQ_SEQ_BYTE_EN
      seq_q       <= seq_d;
`endif
    end
  end

  assign bus.byte_valid = byte_valid;
  assign bus.byte_data  = byte_data;
  assign bus.overflow   = overflow_q;
  assign bus.drop_cnt   = drop_cnt_q;
  assign bus.frame_cnt  = frame_cnt_q;
  assign bus.fifo_level = fifo_level;
endmodule
`default_nettype wire
